// File: rtl/data_memory_param.sv
// Byte-addressed data memory for the MEM stage with valid/ready request and one-cycle response pulse.
// Optional combinational debug read port enabled by defining DMEM_DBG_PORT_EN.
module data_memory_param #(
    parameter  int DEPTH    = 32,
    parameter  int ADDR_W   = 32,
    parameter  int READ_LAT = 1,
    localparam int IDX_W    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    input  logic [IDX_W-1:0]  dbg_idx,
    output logic [31:0]       dbg_data
);

    localparam int                CNT_W     = 2;
    localparam logic [ADDR_W:0]   MEM_BYTES = (ADDR_W+1)'(DEPTH * 4);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [31:0]        pend_rdata_r;
    logic               pend_err_r;
    logic [31:0]        mem_r [DEPTH];

    logic [IDX_W-1:0]   idx_s;
    logic [1:0]         off_s;
    logic               accept_s;
    logic               oor_s;
    logic               illegal_s;
    logic               misal_s;
    logic               err_s;
    logic [31:0]        rd_word_s;
    logic [31:0]        ld_data_s;

    // Lane select and sign/zero extension of a captured word.
    function automatic logic [31:0] ext_load(input logic [31:0] word,
                                             input logic [2:0]  f3,
                                             input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (f3)
            3'b000:  ext_load = {{24{b[7]}}, b};
            3'b001:  ext_load = {{16{h[15]}}, h};
            3'b010:  ext_load = word;
            3'b100:  ext_load = {24'h0, b};
            3'b101:  ext_load = {16'h0, h};
            default: ext_load = 32'h0;
        endcase
    endfunction

    // Byte-lane merge of store data into the old word.
    function automatic logic [31:0] merge_store(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] res;
        res = word;
        case (f3)
            3'b000:  res[{off, 3'b000} +: 8]     = wdata[7:0];
            3'b001:  res[{off[1], 4'b0000} +: 16] = wdata[15:0];
            3'b010:  res = wdata;
            default: res = word;
        endcase
        return res;
    endfunction

    assign idx_s     = req_addr[IDX_W+1:2];
    assign off_s     = req_addr[1:0];
    assign req_ready = (state_r == ST_IDLE) && !rst;
    assign accept_s  = req_valid && req_ready;
    assign oor_s     = ({1'b0, req_addr} >= MEM_BYTES);
    assign rd_word_s = mem_r[idx_s];

    // Classify the request: illegal funct3 and alignment violations.
    always_comb begin
        illegal_s = 1'b0;
        misal_s   = 1'b0;
        if (req_we) begin
            illegal_s = (req_funct3 > 3'b010);
        end else begin
            illegal_s = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                        (req_funct3 == 3'b111);
        end
        case (req_funct3[1:0])
            2'b01:   misal_s = off_s[0];
            2'b10:   misal_s = (off_s != 2'b00);
            default: misal_s = 1'b0;
        endcase
    end

    assign err_s     = oor_s || illegal_s || misal_s;
    assign ld_data_s = (err_s || req_we) ? 32'h0 : ext_load(rd_word_s, req_funct3, off_s);

    // Memory array: cleared by reset, stores commit on the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0;
            end
        end else if (accept_s && req_we && !err_s) begin
            mem_r[idx_s] <= merge_store(rd_word_s, req_wdata, req_funct3, off_s);
        end
    end

    // Request/response FSM with registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            cnt_r        <= {CNT_W{1'b0}};
            pend_rdata_r <= 32'h0;
            pend_err_r   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= 32'h0;
            rsp_err      <= 1'b0;
        end else begin
            rsp_valid <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        pend_rdata_r <= ld_data_s;
                        pend_err_r   <= err_s;
                        if (req_we || (READ_LAT == 1)) begin
                            state_r   <= ST_RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= ld_data_s;
                            rsp_err   <= err_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= CNT_W'(READ_LAT - 2);
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt_r == {CNT_W{1'b0}}) begin
                        state_r   <= ST_RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= pend_rdata_r;
                        rsp_err   <= pend_err_r;
                    end else begin
                        cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_RESP: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef DMEM_DBG_PORT_EN
    assign dbg_data = mem_r[dbg_idx];
`else
    logic unused_dbg_s;
    assign unused_dbg_s = ^dbg_idx;
    assign dbg_data     = 32'h0;
`endif

endmodule

// File: tb/tb_data_memory_param.sv
// Randomized self-checking bench for data_memory_param against a byte-array reference model.
module tb_data_memory_param;

    localparam int DEPTH    = 32;
    localparam int ADDR_W   = 32;
    localparam int READ_LAT = 3;
    localparam int IDX_W    = $clog2(DEPTH);

    logic              clk;
    logic              rst;
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_funct3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;
    logic [IDX_W-1:0]  dbg_idx;
    logic [31:0]       dbg_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]  mdl [DEPTH*4];
    logic [31:0] last_rdata;
    logic        last_err;

    data_memory_param #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .READ_LAT(READ_LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        else if (f3[1:0] == 2'b01) return 2;
        else return 4;
    endfunction

    function automatic logic mdl_err(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        logic bad_f3;
        if (we) bad_f3 = (f3 > 3'd2);
        else    bad_f3 = (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
        return bad_f3 || (addr >= 32'(DEPTH*4)) || ((addr % acc_size(f3)) != 0);
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] addr);
        int          sz;
        logic [31:0] val;
        sz  = acc_size(f3);
        val = 32'h0;
        for (int i = 0; i < sz; i++) val = val | (32'(mdl[int'(addr) + i]) << (8*i));
        if (!f3[2] && sz < 4 && val[8*sz-1])
            val = val | ~((32'd1 << (8*sz)) - 32'd1);
        return val;
    endfunction

    function automatic logic [31:0] mdl_word(input int idx);
        return {mdl[4*idx+3], mdl[4*idx+2], mdl[4*idx+1], mdl[4*idx]};
    endfunction

    // One full request/response transaction; called at #1 after a rising edge.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata);
        logic        e;
        logic [31:0] exp_d;
        logic        ready_seen;
        int          lat;
        int          want_lat;
        e     = mdl_err(we, f3, addr);
        exp_d = (e || we) ? 32'h0 : mdl_load(f3, addr);
        want_lat = we ? 1 : READ_LAT;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        for (int w = 0; w < 10 && !req_ready; w++) begin
            @(posedge clk); #1;
        end
        check_eq("ready_before_req", 32'(req_ready), 32'd1);
        @(posedge clk);
        if (we && !e)
            for (int i = 0; i < acc_size(f3); i++) mdl[int'(addr) + i] = wdata[8*i +: 8];
        #1;
        // Keep a valid store on the bus; the block must ignore it until IDLE.
        req_we = 1'b1; req_funct3 = 3'b010;
        req_addr = 32'($urandom_range(0, DEPTH-1)) << 2;
        req_wdata = $urandom;
        ready_seen = 1'b0;
        lat = 9;
        for (int c = 1; c <= 8; c++) begin
            ready_seen = ready_seen | req_ready;
            if (rsp_valid) begin
                lat = c;
                break;
            end
            check_eq("rdata_hold", rsp_rdata, last_rdata);
            @(posedge clk); #1;
        end
        check_eq("latency", 32'(lat), 32'(want_lat));
        check_eq("ready_low_busy", 32'(ready_seen), 32'd0);
        check_eq("rdata", rsp_rdata, exp_d);
        check_eq("err", 32'(rsp_err), 32'(e));
        last_rdata = exp_d;
        last_err   = e;
        req_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("pulse_one_cycle", 32'(rsp_valid), 32'd0);
        check_eq("ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic        rv_seen;
        logic [2:0]  f3;
        logic [31:0] addr;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; dbg_idx = IDX_W'(2);
        last_rdata = 32'h0; last_err = 1'b0;
        for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h0;
        @(posedge clk); #1;
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rdata", rsp_rdata, 32'h0);
        check_eq("rst_err", 32'(rsp_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        access(1'b0, 3'b010, 32'h0C, 32'h0);
        access(1'b1, 3'b010, 32'h04, 32'h8000_00F1);
        access(1'b0, 3'b000, 32'h04, 32'h0);
        check_eq("lb_sext", last_rdata, 32'hFFFF_FFF1);
        access(1'b0, 3'b100, 32'h04, 32'h0);
        check_eq("lbu_zext", last_rdata, 32'h0000_00F1);
        access(1'b0, 3'b101, 32'h06, 32'h0);
        check_eq("lhu_upper", last_rdata, 32'h0000_8000);

        access(1'b1, 3'b010, 32'h08, 32'h1122_3344);
`ifdef DMEM_DBG_PORT_EN
        check_eq("dbg_word2", dbg_data, 32'h1122_3344);
`else
        check_eq("dbg_tied0", dbg_data, 32'h0);
`endif
        access(1'b1, 3'b000, 32'h09, 32'h0000_00AA);
        access(1'b1, 3'b001, 32'h0A, 32'h0000_BEEF);
        access(1'b0, 3'b010, 32'h08, 32'h0);
        check_eq("merge_word", last_rdata, 32'hBEEF_AA44);

        access(1'b1, 3'b010, 32'h00, 32'h1234_5678);
        access(1'b1, 3'b010, 32'h02, 32'hDEAD_BEEF);
        access(1'b0, 3'b010, 32'h00, 32'h0);
        check_eq("word0_kept", last_rdata, 32'h1234_5678);
        access(1'b0, 3'b001, 32'h03, 32'h0);
        access(1'b0, 3'b010, 32'(DEPTH*4), 32'h0);
        access(1'b0, 3'b011, 32'h00, 32'h0);
        access(1'b1, 3'b100, 32'h00, 32'h0);
        access(1'b0, 3'b010, 32'h8000_0000, 32'h0);

        // Reset while a load sits in WAIT: no response, memory cleared.
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h08;
        @(posedge clk); #1;
        req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_eq("rst_wait_ready", 32'(req_ready), 32'd0);
        check_eq("rst_wait_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < DEPTH*4; i++) mdl[i] = 8'h0;
        last_rdata = 32'h0; last_err = 1'b0;
        rv_seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            rv_seen = rv_seen | rsp_valid;
            @(posedge clk); #1;
        end
        check_eq("no_rsp_after_rst", 32'(rv_seen), 32'd0);
        check_eq("dbg_after_rst", dbg_data, 32'h0);
        access(1'b0, 3'b010, 32'h08, 32'h0);
        check_eq("mem_cleared", last_rdata, 32'h0);

        for (int n = 0; n < 300; n++) begin
            f3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 9))
                0:       addr = $urandom;
                1:       addr = 32'($urandom_range(DEPTH*4, DEPTH*4 + 15));
                default: addr = 32'($urandom_range(0, DEPTH*4 - 1));
            endcase
            if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(acc_size(f3)) - 32'd1);
            dbg_idx = IDX_W'($urandom_range(0, DEPTH-1));
            access(1'($urandom_range(0, 1)), f3, addr, $urandom);
`ifdef DMEM_DBG_PORT_EN
            check_eq("dbg_rand", dbg_data, mdl_word(int'(dbg_idx)));
`else
            check_eq("dbg_rand_tied0", dbg_data, 32'h0);
`endif
        end

        for (int i = 0; i < DEPTH; i++) begin
            access(1'b0, 3'b010, 32'(4*i), 32'h0);
            check_eq("final_word", last_rdata, mdl_word(i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
